// File: rtl/fxf_arb_pkg.sv
// fxf_arb_pkg: shared types, constants and round-robin pick helper for fxf_conv_arbiter
package fxf_arb_pkg;
    localparam int CONV_LATENCY = 7;
    localparam int MAX_REQ = 16;
    localparam int MAX_ID_W = 4;
    typedef logic [MAX_ID_W-1:0] tag_t;
    function automatic logic [MAX_REQ-1:0] onehot_rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input tag_t ptr,
        input int n
    );
        logic [MAX_REQ-1:0] pick;
        int j;
        pick = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            j = (int'(ptr) + k) % n;
            if (k < n && pick == '0 && valid[j[MAX_ID_W-1:0]]) pick[j[MAX_ID_W-1:0]] = 1'b1;
        end
        return pick;
    endfunction
endpackage

// File: rtl/fxf_tag_fifo.sv
// fxf_tag_fifo: in-order requester tag FIFO with simultaneous push/pop
module fxf_tag_fifo #(
    parameter int W = 2,
    parameter int DEPTH = 8,
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    assign head = mem[rd_ptr];
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    always_ff @(posedge aclk)
        if (push) mem[wr_ptr] <= din;
    always_ff @(posedge aclk) begin
        if (aresetn) begin
            count <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            count <= count + CW'(push) - CW'(pop);
            if (push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/fxf_conv_arbiter.sv
// fxf_conv_arbiter: round-robin sharing of one in-order fixed-to-float converter
// among NUM_REQ requesters, with results routed back by an in-order tag FIFO
module fxf_conv_arbiter
    import fxf_arb_pkg::*;
#(
    parameter int SIZE = 64,
    parameter int NUM_REQ = 4,
    parameter int MAX_OUTSTANDING = 8,
    localparam int ID_W = $clog2(NUM_REQ),
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [NUM_REQ*SIZE-1:0] req_tdata,
    input  logic [NUM_REQ-1:0]      req_tvalid,
    output logic [NUM_REQ-1:0]      req_tready,
    output logic [SIZE-1:0]         res_tdata,
    output logic [NUM_REQ-1:0]      res_tvalid,
    input  logic [NUM_REQ-1:0]      res_tready,
    output logic [SIZE-1:0]         conv_a_tdata,
    output logic                    conv_a_tvalid,
    input  logic                    conv_a_tready,
    input  logic [SIZE-1:0]         conv_res_tdata,
    input  logic                    conv_res_tvalid,
    output logic                    conv_res_tready,
    output logic [CNT_W-1:0]        outstanding,
    output logic                    err_sticky
);
    logic [ID_W-1:0] rr_ptr, grant, head;
    logic [MAX_REQ-1:0] pick;
    logic any, full, empty, push, pop;
    assign pick = onehot_rr_pick(MAX_REQ'(req_tvalid), tag_t'(rr_ptr), NUM_REQ);
    assign any = |pick;
    always_comb begin
        grant = '0;
        for (int i = 0; i < NUM_REQ; i++) if (pick[i]) grant = ID_W'(i);
    end
    assign conv_a_tvalid = !aresetn && any && !full;
    assign conv_a_tdata = req_tdata[grant*SIZE +: SIZE];
    assign req_tready = (!aresetn && !full && conv_a_tready) ? pick[NUM_REQ-1:0] : '0;
    assign push = conv_a_tvalid && conv_a_tready;
    // with nothing outstanding the converter output is drained so a stray result cannot wedge it
    assign res_tvalid = (!aresetn && !empty && conv_res_tvalid) ? NUM_REQ'(1) << head : '0;
    assign conv_res_tready = !aresetn && (empty || res_tready[head]);
    assign pop = conv_res_tvalid && conv_res_tready && !empty;
    assign res_tdata = conv_res_tdata;
    always_ff @(posedge aclk) begin
        if (aresetn) begin
            rr_ptr <= '0;
            err_sticky <= 1'b0;
        end else begin
            if (push) rr_ptr <= (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
            if (conv_res_tvalid && empty) err_sticky <= 1'b1;
        end
    end
    fxf_tag_fifo #(.W(ID_W), .DEPTH(MAX_OUTSTANDING)) u_tags (
        .aclk(aclk),
        .aresetn(aresetn),
        .push(push),
        .pop(pop),
        .din(grant),
        .head(head),
        .count(outstanding),
        .full(full),
        .empty(empty)
    );
endmodule

// File: tb/tb_fxf_conv_arbiter.sv
// tb_fxf_conv_arbiter: randomized and directed checks of fxf_conv_arbiter against a
// queue-based model of arbitration, tag ordering and an ideal 7-cycle converter
module tb_fxf_conv_arbiter;
    localparam int SIZE = 64;
    localparam int NR = 4;
    localparam int MAXO = 8;
    localparam int LAT = 7;

    logic aclk = 1'b0;
    logic aresetn = 1'b1;
    logic [NR*SIZE-1:0] req_tdata = '0;
    logic [NR-1:0] req_tvalid = '0;
    logic [NR-1:0] req_tready;
    logic [SIZE-1:0] res_tdata;
    logic [NR-1:0] res_tvalid;
    logic [NR-1:0] res_tready = '0;
    logic [SIZE-1:0] conv_a_tdata;
    logic conv_a_tvalid;
    logic conv_a_tready = 1'b1;
    logic [SIZE-1:0] conv_res_tdata = '0;
    logic conv_res_tvalid = 1'b0;
    logic conv_res_tready;
    logic [3:0] outstanding;
    logic err_sticky;

    fxf_conv_arbiter #(.SIZE(SIZE), .NUM_REQ(NR), .MAX_OUTSTANDING(MAXO)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .req_tdata(req_tdata), .req_tvalid(req_tvalid), .req_tready(req_tready),
        .res_tdata(res_tdata), .res_tvalid(res_tvalid), .res_tready(res_tready),
        .conv_a_tdata(conv_a_tdata), .conv_a_tvalid(conv_a_tvalid), .conv_a_tready(conv_a_tready),
        .conv_res_tdata(conv_res_tdata), .conv_res_tvalid(conv_res_tvalid),
        .conv_res_tready(conv_res_tready), .outstanding(outstanding), .err_sticky(err_sticky)
    );

    always #5 aclk = ~aclk;

    typedef struct { int id; logic [63:0] res; } tag_t;
    typedef struct { logic [63:0] res; int due; } cv_t;
    tag_t mdl_q[$];
    cv_t cq[$];
    int mdl_ptr = 0;
    logic mdl_err = 1'b0;
    logic spur = 1'b0;
    int cyc = 0;
    int tests = 0;
    int failed = 0;
    int last_grant, last_res;
    logic [NR-1:0] last_rdy;
    logic [3:0] last_out;
    logic last_av, last_crr, last_err;

    function automatic logic [63:0] to_dbl(input logic [63:0] x);
        return $realtobits($itor($signed(x)));
    endfunction

    function automatic int exp_grant();
        for (int k = 0; k < NR; k++)
            if (req_tvalid[(mdl_ptr + k) % NR]) return (mdl_ptr + k) % NR;
        return -1;
    endfunction

    task automatic drive_conv();
        if (spur) begin
            conv_res_tvalid = 1'b1;
            conv_res_tdata = 64'hDEAD;
        end else begin
            conv_res_tvalid = cq.size() > 0 && cq[0].due <= cyc;
            conv_res_tdata = cq.size() > 0 ? cq[0].res : '0;
        end
    endtask

    // one clock: settle, check against the model, advance the model, cross the edge
    task automatic cycle();
        int g;
        logic av, crr;
        logic [NR-1:0] rdy, rv;
        logic [63:0] op;
        #1;
        last_grant = -1;
        last_res = -1;
        last_rdy = req_tready;
        last_out = outstanding;
        last_av = conv_a_tvalid;
        last_crr = conv_res_tready;
        last_err = err_sticky;
        if (aresetn) begin
            tests++;
            if (req_tready !== '0 || res_tvalid !== '0 || conv_a_tvalid !== 1'b0 || conv_res_tready !== 1'b0) begin
                failed++;
                $display("FAIL reset_outputs: req_tready=%b res_tvalid=%b conv_a_tvalid=%b conv_res_tready=%b, required all 0",
                         req_tready, res_tvalid, conv_a_tvalid, conv_res_tready);
            end
            mdl_q.delete();
            cq.delete();
            mdl_ptr = 0;
            mdl_err = 1'b0;
            spur = 1'b0;
        end else begin
            g = exp_grant();
            av = g >= 0 && mdl_q.size() < MAXO;
            rdy = (av && conv_a_tready) ? NR'(1 << g) : '0;
            if (mdl_q.size() > 0) begin
                rv = conv_res_tvalid ? NR'(1 << mdl_q[0].id) : '0;
                crr = res_tready[mdl_q[0].id];
            end else begin
                rv = '0;
                crr = 1'b1;
            end
            tests++;
            if (conv_a_tvalid !== av) begin failed++; $display("FAIL conv_a_tvalid @%0d: got %b exp %b", cyc, conv_a_tvalid, av); end
            tests++;
            if (req_tready !== rdy) begin failed++; $display("FAIL req_tready @%0d: got %b exp %b", cyc, req_tready, rdy); end
            if (av) begin
                op = req_tdata[g*SIZE +: SIZE];
                tests++;
                if (conv_a_tdata !== op) begin failed++; $display("FAIL conv_a_tdata @%0d: got %h exp %h", cyc, conv_a_tdata, op); end
            end
            tests++;
            if (outstanding !== 4'(mdl_q.size())) begin failed++; $display("FAIL outstanding @%0d: got %0d exp %0d", cyc, outstanding, mdl_q.size()); end
            tests++;
            if (res_tvalid !== rv) begin failed++; $display("FAIL res_tvalid @%0d: got %b exp %b", cyc, res_tvalid, rv); end
            tests++;
            if (conv_res_tready !== crr) begin failed++; $display("FAIL conv_res_tready @%0d: got %b exp %b", cyc, conv_res_tready, crr); end
            tests++;
            if (res_tdata !== conv_res_tdata) begin failed++; $display("FAIL res_tdata_pass @%0d: got %h exp %h", cyc, res_tdata, conv_res_tdata); end
            tests++;
            if (err_sticky !== mdl_err) begin failed++; $display("FAIL err_sticky @%0d: got %b exp %b", cyc, err_sticky, mdl_err); end
            if (conv_res_tvalid && crr) begin
                if (mdl_q.size() > 0) begin
                    last_res = mdl_q[0].id;
                    tests++;
                    if (conv_res_tdata !== mdl_q[0].res) begin
                        failed++;
                        $display("FAIL result_data @%0d req %0d: got %h exp %h", cyc, mdl_q[0].id, conv_res_tdata, mdl_q[0].res);
                    end
                    void'(mdl_q.pop_front());
                end else mdl_err = 1'b1;
                if (spur) spur = 1'b0;
                else if (cq.size() > 0) void'(cq.pop_front());
            end
            if (av && conv_a_tready) begin
                last_grant = g;
                mdl_q.push_back('{g, to_dbl(req_tdata[g*SIZE +: SIZE])});
                cq.push_back('{to_dbl(conv_a_tdata), cyc + LAT});
                mdl_ptr = (g + 1) % NR;
            end
        end
        @(posedge aclk);
        cyc++;
        #1;
        drive_conv();
    endtask

    task automatic do_reset();
        aresetn = 1'b1;
        cycle();
        aresetn = 1'b0;
    endtask

    task automatic drain();
        int k;
        req_tvalid = '0;
        res_tready = '1;
        conv_a_tready = 1'b1;
        for (k = 0; k < 200 && (mdl_q.size() > 0 || cq.size() > 0); k++) cycle();
        tests++;
        if (mdl_q.size() > 0 || cq.size() > 0) begin
            failed++;
            $display("FAIL drain_timeout: %0d tags / %0d results left, required 0", mdl_q.size(), cq.size());
        end
    endtask

    task automatic test_reset();
        res_tready = '0;
        do_reset();
        do_reset();
        cycle();
        tests++;
        if (last_out !== 4'd0 || last_err !== 1'b0) begin
            failed++;
            $display("FAIL reset_state: outstanding=%0d err_sticky=%b, required 0/0", last_out, last_err);
        end
    endtask

    task automatic test_basic_routing();
        int n, got, first_issue, first_res;
        n = 1; got = 0; first_issue = -1; first_res = -1;
        res_tready = '1;
        conv_a_tready = 1'b1;
        for (int k = 0; k < 80 && (n <= 5 || mdl_q.size() > 0); k++) begin
            req_tvalid = (n <= 5) ? 4'b0010 : 4'b0000;
            req_tdata[SIZE +: SIZE] = 64'(n);
            cycle();
            if (last_grant == 1) begin
                if (first_issue < 0) first_issue = cyc - 1;
                n++;
            end
            if (last_res == 1) begin
                got++;
                if (first_res < 0) first_res = cyc - 1;
            end
        end
        tests++;
        if (got != 5) begin failed++; $display("FAIL basic_count: got %0d results, required 5", got); end
        tests++;
        if (first_res - first_issue != LAT) begin
            failed++;
            $display("FAIL basic_latency: got %0d cycles, required %0d", first_res - first_issue, LAT);
        end
        drain();
    endtask

    task automatic test_round_robin();
        int expg, max_out;
        logic [NR-1:0] want;
        expg = mdl_ptr;
        max_out = 0;
        res_tready = '1;
        conv_a_tready = 1'b1;
        req_tvalid = '1;
        for (int i = 0; i < NR; i++) req_tdata[i*SIZE +: SIZE] = 64'($urandom);
        for (int k = 0; k < 30; k++) begin
            cycle();
            want = NR'(1 << expg);
            tests++;
            if (last_rdy !== want) begin failed++; $display("FAIL rr_order @%0d: got %b exp %b", cyc - 1, last_rdy, want); end
            expg = (expg + 1) % NR;
            if (int'(last_out) > max_out) max_out = int'(last_out);
            for (int i = 0; i < NR; i++) if (last_rdy[i]) req_tdata[i*SIZE +: SIZE] = 64'($urandom);
        end
        tests++;
        if (max_out != LAT) begin failed++; $display("FAIL rr_saturation: got %0d, required %0d", max_out, LAT); end
        drain();
    endtask

    task automatic test_outstanding_cap();
        res_tready = 4'b1011;
        conv_a_tready = 1'b1;
        req_tvalid = 4'b0100;
        req_tdata[2*SIZE +: SIZE] = 64'd42;
        cycle();
        tests++;
        if (last_rdy !== 4'b0100) begin failed++; $display("FAIL cap_head_issue: got %b exp 0100", last_rdy); end
        req_tvalid = '1;
        for (int k = 0; k < 12; k++) cycle();
        tests++;
        if (last_out !== 4'd8 || last_av !== 1'b0 || last_rdy !== '0 || last_crr !== 1'b0) begin
            failed++;
            $display("FAIL cap_full: outstanding=%0d conv_a_tvalid=%b req_tready=%b conv_res_tready=%b, required 8/0/0000/0",
                     last_out, last_av, last_rdy, last_crr);
        end
        res_tready = '1;
        cycle();
        tests++;
        if (last_rdy !== '0 || last_res != 2) begin
            failed++;
            $display("FAIL cap_pop_cycle: req_tready=%b popped=%0d, required 0000 and req 2", last_rdy, last_res);
        end
        cycle();
        tests++;
        if (last_rdy === '0) begin failed++; $display("FAIL cap_resume: req_tready=%b, required a grant", last_rdy); end
        drain();
    endtask

    task automatic test_backpressure();
        do_reset();
        res_tready = '1;
        conv_a_tready = 1'b0;
        req_tvalid = 4'b0101;
        req_tdata[0 +: SIZE] = 64'd7;
        req_tdata[2*SIZE +: SIZE] = 64'd9;
        for (int k = 0; k < 3; k++) begin
            cycle();
            tests++;
            if (last_rdy !== '0 || last_out !== 4'd0 || last_av !== 1'b1) begin
                failed++;
                $display("FAIL bp_stall: req_tready=%b outstanding=%0d conv_a_tvalid=%b, required 0000/0/1", last_rdy, last_out, last_av);
            end
        end
        conv_a_tready = 1'b1;
        cycle();
        tests++;
        if (last_rdy !== 4'b0001) begin failed++; $display("FAIL bp_first_grant: got %b exp 0001", last_rdy); end
        cycle();
        tests++;
        if (last_rdy !== 4'b0100) begin failed++; $display("FAIL bp_second_grant: got %b exp 0100", last_rdy); end
        drain();
    endtask

    task automatic test_random();
        last_rdy = '0;
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < NR; i++)
                if (!req_tvalid[i] || last_rdy[i]) begin
                    req_tvalid[i] = 1'($urandom_range(0, 1));
                    req_tdata[i*SIZE +: SIZE] = 64'($urandom);
                end
            res_tready = NR'($urandom);
            conv_a_tready = $urandom_range(0, 3) != 0;
            cycle();
        end
        drain();
    endtask

    task automatic test_spurious();
        spur = 1'b1;
        drive_conv();
        cycle();
        tests++;
        if (last_crr !== 1'b1 || last_err !== 1'b0) begin
            failed++;
            $display("FAIL spur_accept: conv_res_tready=%b err_sticky=%b, required 1/0", last_crr, last_err);
        end
        for (int k = 0; k < 3; k++) begin
            cycle();
            tests++;
            if (last_err !== 1'b1) begin failed++; $display("FAIL spur_sticky: err_sticky=%b, required 1", last_err); end
        end
    endtask

    task automatic test_reset_mid();
        res_tready = '0;
        conv_a_tready = 1'b1;
        req_tvalid = 4'b1000;
        cycle();
        req_tvalid = 4'b0001;
        cycle();
        req_tvalid = 4'b0010;
        cycle();
        req_tvalid = '1;
        aresetn = 1'b1;
        cycle();
        tests++;
        if (last_out !== 4'd3) begin failed++; $display("FAIL mid_setup: outstanding=%0d, required 3", last_out); end
        aresetn = 1'b0;
        cycle();
        tests++;
        if (last_out !== 4'd0 || last_err !== 1'b0 || last_rdy !== 4'b0001) begin
            failed++;
            $display("FAIL mid_after_reset: outstanding=%0d err_sticky=%b req_tready=%b, required 0/0/0001",
                     last_out, last_err, last_rdy);
        end
        drain();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_routing();
        test_round_robin();
        test_outstanding_cap();
        test_backpressure();
        test_random();
        test_spurious();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
